// File: rtl/phase_pkg.sv
// +----------------------------------------------------------------------+
// | phase_pkg: shared state encoding and default timing for the lane      |
// | phase scheduler.                                     Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

package phase_pkg;

    localparam int STATE_W = 3;
    localparam int LANE_W  = 3;
    localparam int CNT_W   = 7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_ALL_RED = 3'd3,
        ST_EMG     = 3'd4
    } state_t;

    localparam int GREEN_MIN_DEF = 10;
    localparam int GREEN_MAX_DEF = 60;
    localparam int YELLOW_T_DEF  = 3;
    localparam int ALLRED_T_DEF  = 2;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick: combinational round-robin lane picker, searching from        |
// | i_last+1 upward with wrap.                           Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick (
    input  logic [7:0] i_req,
    input  logic [2:0] i_last,
    output logic       o_valid,
    output logic [2:0] o_idx
);

    logic [2:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        // Scan farthest-first so the nearest requester after i_last wins.
        for (int k = 8; k >= 1; k--) begin
            w_cand = i_last + 3'(k);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lane_phase_scheduler.sv
// +----------------------------------------------------------------------+
// | lane_phase_scheduler: eight-lane signal phase controller with         |
// | round-robin service and emergency preemption.        Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module lane_phase_scheduler
    import phase_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_DEF,
    parameter int GREEN_MAX = GREEN_MAX_DEF,
    parameter int YELLOW_T  = YELLOW_T_DEF,
    parameter int ALLRED_T  = ALLRED_T_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         req,
    input  logic               emg_req,
    input  logic [LANE_W-1:0]  emg_lane,
    output logic [7:0]         green,
    output logic [7:0]         yellow,
    output logic [STATE_W-1:0] phase,
    output logic [LANE_W-1:0]  active_lane
);

    localparam logic [CNT_W-1:0] c_GREEN_LOAD  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] c_YELLOW_LOAD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_ALLRED_LOAD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] c_MIN_THRESH  = CNT_W'(GREEN_MAX - GREEN_MIN);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [LANE_W-1:0]   r_last, w_last_nxt;
    logic [LANE_W-1:0]   r_active, w_active_nxt;
    logic                r_min_met, w_min_nxt;

    logic                w_rr_valid;
    logic [LANE_W-1:0]   w_rr_idx;
    logic [7:0]          w_lane_oh;
    logic                w_others;
    logic                w_timeout;
    logic                w_min_ok;

    rr_pick u_rr_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_valid (w_rr_valid),
        .o_idx   (w_rr_idx)
    );

    assign w_lane_oh = 8'b1 << r_last;
    assign w_others  = |(req & ~w_lane_oh);
    assign w_timeout = (r_cnt == '0);
    // The counter spans GREEN_MAX; the minimum dwell is a threshold inside that
    // window, latched so a GREEN_MAX reload does not re-impose it.
    assign w_min_ok  = r_min_met || (r_cnt <= c_MIN_THRESH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_last    <= 3'd7;
            r_active  <= '0;
            r_min_met <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_active  <= w_active_nxt;
            r_min_met <= w_min_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = w_timeout ? r_cnt : r_cnt - CNT_W'(1);
        w_last_nxt   = r_last;
        w_active_nxt = r_active;
        w_min_nxt    = r_min_met;
        case (r_state)
            ST_IDLE: begin
                if (emg_req) begin
                    w_state_nxt  = ST_EMG;
                    w_cnt_nxt    = '0;
                    w_last_nxt   = emg_lane;
                    w_active_nxt = emg_lane;
                end else if (w_rr_valid) begin
                    w_state_nxt  = ST_GREEN;
                    w_cnt_nxt    = c_GREEN_LOAD;
                    w_last_nxt   = w_rr_idx;
                    w_active_nxt = w_rr_idx;
                    w_min_nxt    = 1'b0;
                end
            end
            ST_GREEN: begin
                w_min_nxt = w_min_ok;
                if (emg_req && (emg_lane == r_last)) begin
                    w_state_nxt  = ST_EMG;
                    w_cnt_nxt    = '0;
                    w_last_nxt   = emg_lane;
                    w_active_nxt = emg_lane;
                end else if (emg_req || (w_min_ok && (w_others || !req[r_last]))) begin
                    w_state_nxt = ST_YELLOW;
                    w_cnt_nxt   = c_YELLOW_LOAD;
                end else if (w_timeout) begin
                    w_cnt_nxt = c_GREEN_LOAD;
                end
            end
            ST_YELLOW: begin
                if (w_timeout) begin
                    w_state_nxt = ST_ALL_RED;
                    w_cnt_nxt   = c_ALLRED_LOAD;
                end
            end
            ST_ALL_RED: begin
                if (w_timeout) begin
                    if (emg_req) begin
                        w_state_nxt  = ST_EMG;
                        w_cnt_nxt    = '0;
                        w_last_nxt   = emg_lane;
                        w_active_nxt = emg_lane;
                    end else if (w_rr_valid) begin
                        w_state_nxt  = ST_GREEN;
                        w_cnt_nxt    = c_GREEN_LOAD;
                        w_last_nxt   = w_rr_idx;
                        w_active_nxt = w_rr_idx;
                        w_min_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_EMG: begin
                if (!emg_req) begin
                    w_state_nxt = ST_YELLOW;
                    w_cnt_nxt   = c_YELLOW_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        case (r_state)
            ST_GREEN, ST_EMG: green  = w_lane_oh;
            ST_YELLOW:        yellow = w_lane_oh;
            default:          ;
        endcase
    end

    assign phase       = r_state;
    assign active_lane = r_active;

endmodule

`default_nettype wire

// File: tb/tb_lane_phase_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_lane_phase_scheduler: directed and randomized checks of the lane   |
// | phase scheduler against a behavioural model.         Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lane_phase_scheduler;
    import phase_pkg::*;

    localparam int T_GMIN = 10;
    localparam int T_GMAX = 60;
    localparam int T_YEL  = 3;
    localparam int T_AR   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       emg_req = 1'b0;
    logic [2:0] emg_lane = '0;
    logic [7:0] green, yellow;
    logic [2:0] phase, active_lane;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: elapsed-cycle counts per phase rather than a timer.
    state_t     m_st;
    logic [2:0] m_lane, m_last, m_active;
    int         m_el, m_gt;

    lane_phase_scheduler #(
        .GREEN_MIN (T_GMIN),
        .GREEN_MAX (T_GMAX),
        .YELLOW_T  (T_YEL),
        .ALLRED_T  (T_AR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .emg_req     (emg_req),
        .emg_lane    (emg_lane),
        .green       (green),
        .yellow      (yellow),
        .phase       (phase),
        .active_lane (active_lane)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    function automatic int rr_next(input logic [7:0] r, input logic [2:0] last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(int'(last) + k) % 8]) return (int'(last) + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_st = ST_IDLE; m_last = 3'd7; m_active = 3'd0; m_lane = 3'd0; m_el = 0; m_gt = 0;
    endtask

    task automatic go_green(input int l);
        m_st = ST_GREEN; m_lane = 3'(l); m_last = 3'(l); m_active = 3'(l); m_gt = 1;
    endtask

    task automatic go_emg();
        m_st = ST_EMG; m_lane = emg_lane; m_last = emg_lane; m_active = emg_lane;
    endtask

    task automatic go_timed(input state_t s);
        m_st = s; m_el = 1;
    endtask

    task automatic model_edge();
        logic [7:0] others;
        int         nxt;
        if (!rst) begin
            model_reset();
            return;
        end
        others = req & ~(8'b1 << m_lane);
        nxt    = rr_next(req, m_last);
        case (m_st)
            ST_IDLE:
                if (emg_req) go_emg();
                else if (nxt >= 0) go_green(nxt);
            ST_GREEN:
                if (emg_req) begin
                    if (emg_lane == m_lane) go_emg();
                    else go_timed(ST_YELLOW);
                end else if (m_gt >= T_GMIN && (others != 0 || !req[m_lane])) go_timed(ST_YELLOW);
                else m_gt++;
            ST_YELLOW:
                if (m_el >= T_YEL) go_timed(ST_ALL_RED);
                else m_el++;
            ST_ALL_RED:
                if (m_el >= T_AR) begin
                    if (emg_req) go_emg();
                    else if (nxt >= 0) go_green(nxt);
                    else m_st = ST_IDLE;
                end else m_el++;
            ST_EMG:
                if (!emg_req) go_timed(ST_YELLOW);
            default: model_reset();
        endcase
    endtask

    function automatic logic [21:0] model_out();
        logic [7:0] g, y;
        g = '0;
        y = '0;
        if (m_st == ST_GREEN || m_st == ST_EMG) g = 8'b1 << m_lane;
        if (m_st == ST_YELLOW) y = 8'b1 << m_lane;
        return {g, y, 3'(m_st), m_active};
    endfunction

    function automatic logic [21:0] dut_out();
        return {green, yellow, phase, active_lane};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        req = '0; emg_req = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (dut_out() !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_state: got=%h exp=%h", dut_out(), 22'h0);
        end
        step();
        step();
        n_tests++;
        if (dut_out() !== model_out()) begin
            n_fail++;
            $display("FAIL reset_hold: got=%h exp=%h", dut_out(), model_out());
        end
        rst = 1'b1;
    endtask

    task automatic test_single_lane();
        apply_reset();
        req = 8'h01;
        for (int c = 1; c <= 12; c++) begin
            step();
            n_tests++;
            if (green !== 8'h01 || yellow !== 8'h00) begin
                n_fail++;
                $display("FAIL single_lane c=%0d: green=%h yellow=%h exp green=01", c, green, yellow);
            end
        end
        req = 8'h00;
        for (int c = 0; c < 20; c++) begin
            step();
            n_tests++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL single_lane_release c=%0d: got=%h exp=%h", c, dut_out(), model_out());
            end
        end
    endtask

    task automatic test_two_lanes();
        logic [7:0] lane_oh, eg, ey;
        int p;
        apply_reset();
        req = 8'h81;
        for (int c = 1; c <= 45; c++) begin
            step();
            p = (c - 1) % 15;
            lane_oh = (((c - 1) / 15) % 2 == 0) ? 8'h01 : 8'h80;
            eg = (p < 10) ? lane_oh : 8'h00;
            ey = (p >= 10 && p < 13) ? lane_oh : 8'h00;
            n_tests++;
            if (green !== eg || yellow !== ey) begin
                n_fail++;
                $display("FAIL two_lanes c=%0d: green=%h yellow=%h exp green=%h yellow=%h", c, green, yellow, eg, ey);
            end
            n_tests++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL two_lanes_model c=%0d: got=%h exp=%h", c, dut_out(), model_out());
            end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        req = 8'h04;
        for (int c = 1; c <= 200; c++) begin
            step();
            n_tests++;
            if (green !== 8'h04 || yellow !== 8'h00) begin
                n_fail++;
                $display("FAIL hold c=%0d: green=%h yellow=%h exp green=04", c, green, yellow);
            end
        end
    endtask

    task automatic test_emg_preempt();
        apply_reset();
        req = 8'h08;
        step();
        step();
        emg_req = 1'b1;
        emg_lane = 3'd5;
        step();
        n_tests++;
        if (yellow !== 8'h08 || green !== 8'h00) begin
            n_fail++;
            $display("FAIL emg_preempt_yellow: green=%h yellow=%h exp yellow=08", green, yellow);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_tests++;
            if (green !== 8'h00 || yellow !== ((i <= 2) ? 8'h08 : 8'h00)) begin
                n_fail++;
                $display("FAIL emg_clear i=%0d: green=%h yellow=%h", i, green, yellow);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if (green !== 8'h20 || phase !== ST_EMG) begin
                n_fail++;
                $display("FAIL emg_hold i=%0d: green=%h phase=%0d exp green=20 phase=%0d", i, green, phase, ST_EMG);
            end
        end
        emg_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            n_tests++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL emg_exit i=%0d: got=%h exp=%h", i, dut_out(), model_out());
            end
        end
    endtask

    task automatic test_emg_same_lane();
        apply_reset();
        req = 8'h20;
        step();
        step();
        emg_req = 1'b1;
        emg_lane = 3'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (green !== 8'h20 || yellow !== 8'h00 || phase !== ST_EMG) begin
                n_fail++;
                $display("FAIL emg_same_lane i=%0d: green=%h yellow=%h phase=%0d", i, green, yellow, phase);
            end
        end
        emg_req = 1'b0;
        step();
        n_tests++;
        if (yellow !== 8'h20 || green !== 8'h00) begin
            n_fail++;
            $display("FAIL emg_same_exit: green=%h yellow=%h exp yellow=20", green, yellow);
        end
    endtask

    task automatic test_reset_mid_yellow();
        logic found;
        found = 1'b0;
        apply_reset();
        req = 8'h01;
        for (int c = 0; c < 40; c++) begin
            step();
            if (c == 3) req = 8'h00;
            if (phase === ST_YELLOW) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_yellow_reach: phase=%0d exp=%0d", phase, ST_YELLOW);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (green !== 8'h00 || yellow !== 8'h00 || phase !== ST_IDLE) begin
            n_fail++;
            $display("FAIL rst_mid_yellow: green=%h yellow=%h phase=%0d exp 0/0/%0d", green, yellow, phase, ST_IDLE);
        end
        step();
        rst = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                model_reset();
            end
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = '0;
                    1:       req = 8'b1 << $urandom_range(0, 7);
                    default: req = 8'($urandom & $urandom);
                endcase
            end
            if (!emg_req && $urandom_range(0, 79) == 0) emg_req = 1'b1;
            else if (emg_req && $urandom_range(0, 14) == 0) emg_req = 1'b0;
            if ($urandom_range(0, 4) == 0) emg_lane = 3'($urandom_range(0, 7));
            #1;
            n_tests++;
            if (dut_out() !== model_out()) begin
                n_fail++;
                $display("FAIL random c=%0d: got=%h exp=%h", c, dut_out(), model_out());
            end
            n_tests++;
            if ($countones({green, yellow}) > 1) begin
                n_fail++;
                $display("FAIL one_hot c=%0d: green=%h yellow=%h", c, green, yellow);
            end
            step();
        end
        rst = 1'b1;
        emg_req = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_lane();
        test_two_lanes();
        test_hold();
        test_emg_preempt();
        test_emg_same_lane();
        test_reset_mid_yellow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lane_phase_scheduler.md
LANE_PHASE_SCHEDULER -- requirements
Module: lane_phase_scheduler

Interface
REQ-001 SHALL have parameter GREEN_MIN, default 10: minimum green dwell in clk cycles (range 1..127).
REQ-002 SHALL have parameter GREEN_MAX, default 60: maximum green dwell in cycles when other lanes wait (range GREEN_MIN..127).
REQ-003 SHALL have parameter YELLOW_T, default 3: yellow clearance in cycles (range 1..127).
REQ-004 SHALL have parameter ALLRED_T, default 2: all-red clearance in cycles (range 1..127).
REQ-005 SHALL have port clk  input  1: single 1 s system clock, rising edge.
REQ-006 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  8: per-lane vehicle-waiting request, bit i = lane i.
REQ-008 SHALL have port emg_req  input  1: emergency preemption request, level.
REQ-009 SHALL have port emg_lane  input  3: lane index granted during emergency.
REQ-010 SHALL have port green  output  8: one-hot green lane, all-zero when none.
REQ-011 SHALL have port yellow  output  8: one-hot yellow lane, all-zero when none.
REQ-012 SHALL have port phase  output  3: current state encoding from the shared package.
REQ-013 SHALL have port active_lane  output  3: lane currently green or yellow, else last served lane.

Function
REQ-014 SHALL implement states IDLE, GREEN, YELLOW, ALL_RED, EMG; outputs decoded from registered state only (Moore).
REQ-015 SHALL use a 7-bit down-counter loaded with duration-1 on state entry; state timeout = counter 0.
REQ-016 IDLE: all red; on any req bit set, SHALL pick a lane round-robin starting at last_served+1 (wrapping 7->0) and enter GREEN next cycle.
REQ-017 GREEN SHALL last at least GREEN_MIN cycles, except on emergency preemption.
REQ-018 After GREEN_MIN: if any other lane requests, or own req is low, SHALL enter YELLOW; else stay GREEN.
REQ-019 At GREEN_MAX with any other lane requesting, SHALL enter YELLOW regardless of own req; with no other requests, SHALL restart the GREEN_MAX count and stay GREEN.
REQ-020 YELLOW SHALL last YELLOW_T cycles, then ALL_RED for ALLRED_T cycles.
REQ-021 On ALL_RED expiry: emg_req high -> EMG; any req -> GREEN on next round-robin lane; else IDLE.
REQ-022 last_served SHALL update to the granted lane on GREEN or EMG entry.
REQ-023 emg_req in GREEN on lane != emg_lane SHALL force YELLOW next cycle, ignoring GREEN_MIN; in GREEN on lane == emg_lane SHALL go directly to EMG; in IDLE SHALL go directly to EMG; in YELLOW/ALL_RED it takes effect at ALL_RED expiry.
REQ-024 EMG: green on emg_lane (sampled on entry, held) until emg_req falls, then YELLOW then ALL_RED.
REQ-025 Simultaneous emg_req and req SHALL be resolved in favour of emg_req.
REQ-026 green and yellow SHALL never both be non-zero; at most one bit total across both vectors.
REQ-027 req changes during YELLOW or ALL_RED SHALL NOT alter the clearance sequence.

Reset
REQ-028 On rst low, SHALL asynchronously enter IDLE: green=0, yellow=0, phase=IDLE, active_lane=0, last_served=7, counter=0.
REQ-029 Reset asserted mid-GREEN or mid-EMG SHALL drop to all red immediately, without yellow.
REQ-030 After rst release, the first grant SHALL go to lane 0 if req[0] is set.

Structure
REQ-031 State enum, state width, and default timing constants SHALL live in shared package phase_pkg.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_pick (8-bit req, 3-bit last, outputs valid and 3-bit index).

Verification
REQ-033 Reset, req=8'h01 -> green=8'h01 one cycle after rst release, held 10 cycles minimum.
REQ-034 req=8'h81 held -> lane 0 green 10 cycles, yellow 3, all-red 2, lane 7 green; then lane 0 again.
REQ-035 req=8'h04 only, held 200 cycles -> lane 2 stays green throughout, no yellow.
REQ-036 Lane 3 green at cycle 2 of GREEN, emg_req=1, emg_lane=5 -> yellow on lane 3 next cycle, 3 yellow, 2 all-red, green=8'h20 until emg_req low.
REQ-037 Lane 5 green, emg_req=1, emg_lane=5 -> green stays 8'h20 with no clearance gap, phase=EMG.
REQ-038 rst low mid-yellow -> green=yellow=0 within the same cycle, phase=IDLE.
